// File: rtl/uart_sram_pkg.sv
// Shared types and helpers for the UART-to-SRAM loader.
// Lane 0 is the most significant byte of the SRAM word.
package uart_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_WAIT,
        ST_HDR_ACK,
        ST_BYTE_WAIT,
        ST_BYTE_ACK,
        ST_WRITE,
        ST_DONE
    } loader_state_t;

    localparam logic [7:0] LF_CHAR = 8'h0A;

    function automatic int lane_of(input int byte_idx, input bit msb_first, input int bpw);
        return msb_first ? byte_idx : (bpw - 1 - byte_idx);
    endfunction

endpackage

// File: rtl/uart_byte_handshake.sv
// Empty/Unload handshake with the UART receiver, shared by the header and data phases.
// byte_valid marks the cycle a byte is taken; ack_done marks the receiver releasing it.
module uart_byte_handshake (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       clear,
    input  logic       wait_active,
    input  logic       ack_active,
    input  logic       RX_empty,
    input  logic [7:0] RX_data,
    output logic       RX_unload,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       ack_done
);

    assign byte_valid = wait_active & ~RX_empty;
    assign byte_data  = RX_data;
    assign ack_done   = ack_active & RX_empty;

    // Unload rises with the capture and drops on the edge that sees Empty return.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            RX_unload <= 1'b0;
        end else if (clear) begin
            RX_unload <= 1'b0;
        end else if (byte_valid) begin
            RX_unload <= 1'b1;
        end else if (ack_done) begin
            RX_unload <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_sram_loader.sv
// Assembles UART bytes into DATA_W-bit words and writes them over [Start_addr..Last_addr].
// Optional byte checksum on the Checksum port when UART_SRAM_CHECKSUM_EN is defined.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | waiting for Enable; window latched on accept
//   HDR_WAIT  | waiting for a header byte
//   HDR_ACK   | header byte taken, waiting for Empty
//   BYTE_WAIT | waiting for a data byte
//   BYTE_ACK  | data byte taken, waiting for Empty
//   WRITE     | SRAM_we_n low for this single cycle
//   DONE      | window filled (or empty window); held until Initialize
module uart_sram_loader
    import uart_sram_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 18,
    parameter int HEADER_LINES = 3,
    parameter int MSB_FIRST    = 1
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Initialize,
    input  logic              Enable,
    input  logic              Header_en,
    input  logic [ADDR_W-1:0] Start_addr,
    input  logic [ADDR_W-1:0] Last_addr,
    input  logic [7:0]        RX_data,
    input  logic              RX_empty,
    output logic              RX_unload,
    output logic              RX_enable,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [DATA_W-1:0] SRAM_write_data,
    output logic              SRAM_we_n,
    output logic              Busy,
    output logic              Done,
    output logic [15:0]       Checksum
);

    localparam int BPW   = DATA_W / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int LSB_W = $clog2(DATA_W);

    loader_state_t     state;
    logic [IDX_W-1:0]  byte_idx;
    logic [3:0]        lf_cnt;
    logic [ADDR_W-1:0] last_addr_q;
    logic [LSB_W-1:0]  lane_lsb;

    logic wait_active;
    logic ack_active;
    logic byte_valid;
    logic ack_done;
    logic [7:0] byte_data;

    assign wait_active = (state == ST_HDR_WAIT) || (state == ST_BYTE_WAIT);
    assign ack_active  = (state == ST_HDR_ACK)  || (state == ST_BYTE_ACK);

    uart_byte_handshake u_handshake (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .clear       (Initialize),
        .wait_active (wait_active),
        .ack_active  (ack_active),
        .RX_empty    (RX_empty),
        .RX_data     (RX_data),
        .RX_unload   (RX_unload),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .ack_done    (ack_done)
    );

    // Bit position of the lane that the current byte index fills.
    always_comb begin
        lane_lsb = LSB_W'((BPW - 1 - lane_of(32'(byte_idx), MSB_FIRST != 0, BPW)) * 8);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state           <= ST_IDLE;
            byte_idx        <= '0;
            lf_cnt          <= '0;
            last_addr_q     <= '0;
            RX_enable       <= 1'b0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            Busy            <= 1'b0;
            Done            <= 1'b0;
        end else if (Initialize) begin
            state           <= ST_IDLE;
            byte_idx        <= '0;
            lf_cnt          <= '0;
            last_addr_q     <= '0;
            RX_enable       <= 1'b0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            Busy            <= 1'b0;
            Done            <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Enable) begin
                        last_addr_q  <= Last_addr;
                        SRAM_address <= Start_addr;
                        byte_idx     <= '0;
                        lf_cnt       <= '0;
                        if (Start_addr > Last_addr) begin
                            Done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            RX_enable <= 1'b1;
                            Busy      <= 1'b1;
                            state     <= Header_en ? ST_HDR_WAIT : ST_BYTE_WAIT;
                        end
                    end
                end
                ST_HDR_WAIT: begin
                    if (byte_valid) begin
                        if (byte_data == LF_CHAR) begin
                            lf_cnt <= lf_cnt + 4'd1;
                        end
                        state <= ST_HDR_ACK;
                    end
                end
                ST_HDR_ACK: begin
                    if (ack_done) begin
                        state <= (lf_cnt == 4'(HEADER_LINES)) ? ST_BYTE_WAIT : ST_HDR_WAIT;
                    end
                end
                ST_BYTE_WAIT: begin
                    if (byte_valid) begin
                        SRAM_write_data[lane_lsb +: 8] <= byte_data;
                        state <= ST_BYTE_ACK;
                    end
                end
                ST_BYTE_ACK: begin
                    if (ack_done) begin
                        if (byte_idx == IDX_W'(BPW - 1)) begin
                            byte_idx  <= '0;
                            SRAM_we_n <= 1'b0;
                            state     <= ST_WRITE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= ST_BYTE_WAIT;
                        end
                    end
                end
                ST_WRITE: begin
                    SRAM_we_n <= 1'b1;
                    // Compare before incrementing so the address can never wrap.
                    if (SRAM_address == last_addr_q) begin
                        RX_enable <= 1'b0;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        SRAM_address <= SRAM_address + 1'b1;
                        state        <= ST_BYTE_WAIT;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_SRAM_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            checksum_q <= 16'd0;
        end else if (Initialize) begin
            checksum_q <= 16'd0;
        end else if ((state == ST_IDLE) && Enable) begin
            checksum_q <= 16'd0;
        end else if ((state == ST_BYTE_WAIT) && byte_valid) begin
            checksum_q <= checksum_q + {8'd0, byte_data};
        end
    end

    assign Checksum = checksum_q;
`else
    assign Checksum = 16'd0;
`endif

endmodule

// File: tb/tb_uart_sram_loader.sv
// Bench for uart_sram_loader: a 16-bit MSB-first instance and a 32-bit LSB-first instance
// share control inputs; a stream-level model predicts every SRAM write.
module tb_uart_sram_loader;

    typedef struct {
        int unsigned addr;
        logic [63:0] data;
    } wr_t;

`ifdef UART_SRAM_CHECKSUM_EN
    localparam logic [15:0] CS_S1 = 16'h0165;
`else
    localparam logic [15:0] CS_S1 = 16'h0000;
`endif

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Initialize = 1'b0;
    logic        Enable = 1'b0;
    logic        Header_en = 1'b0;
    logic [17:0] Start_addr = '0;
    logic [17:0] Last_addr = '0;
    logic [7:0]  rx_data [2];
    logic        rx_empty [2];

    logic        unl_a, en_a, we_a, busy_a, done_a;
    logic [17:0] addr_a;
    logic [15:0] data_a, cs_a;
    logic        unl_b, en_b, we_b, busy_b, done_b;
    logic [17:0] addr_b;
    logic [31:0] data_b;
    logic [15:0] cs_b;

    int checks = 0;
    int errors = 0;
    wr_t exp_q [2][$];
    int wr_cnt [2];
    logic prev_we [2];
    logic [17:0] prev_addr [2];
    logic [63:0] prev_data [2];
    logic [17:0] last_wa [2];
    logic [63:0] last_wd [2];

    always #5 Clock = ~Clock;

    uart_sram_loader dut_a (
        .Clock(Clock), .Resetn(Resetn), .Initialize(Initialize), .Enable(Enable),
        .Header_en(Header_en), .Start_addr(Start_addr), .Last_addr(Last_addr),
        .RX_data(rx_data[0]), .RX_empty(rx_empty[0]), .RX_unload(unl_a), .RX_enable(en_a),
        .SRAM_address(addr_a), .SRAM_write_data(data_a), .SRAM_we_n(we_a),
        .Busy(busy_a), .Done(done_a), .Checksum(cs_a)
    );

    uart_sram_loader #(.DATA_W(32), .MSB_FIRST(0)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .Initialize(Initialize), .Enable(Enable),
        .Header_en(Header_en), .Start_addr(Start_addr), .Last_addr(Last_addr),
        .RX_data(rx_data[1]), .RX_empty(rx_empty[1]), .RX_unload(unl_b), .RX_enable(en_b),
        .SRAM_address(addr_b), .SRAM_write_data(data_b), .SRAM_we_n(we_b),
        .Busy(busy_b), .Done(done_b), .Checksum(cs_b)
    );

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] req);
        $display("FAIL %s actual=%0h required=%0h", name, act, req);
        errors++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) fail(name, act, req);
    endtask

    function automatic logic get_unl(input int i);
        return (i == 0) ? unl_a : unl_b;
    endfunction

    function automatic logic get_done(input int i);
        return (i == 0) ? done_a : done_b;
    endfunction

    // Stream-level model: which words land where, and how many bytes get consumed.
    function automatic int model(input int i, input logic [7:0] b[$], input int unsigned start,
                                 input int unsigned last, input bit hdr);
        int bpw = (i == 0) ? 2 : 4;
        bit msb = (i == 0);
        int lf = 0;
        int k = 0;
        int unsigned a = start;
        logic [63:0] w;
        wr_t e;
        if (start > last) return 0;
        if (hdr) begin
            while (lf < 3 && k < b.size()) begin
                if (b[k] == 8'h0A) lf++;
                k++;
            end
        end
        while (k + bpw <= b.size() && a <= last) begin
            w = '0;
            for (int j = 0; j < bpw; j++) begin
                if (msb) w = (w << 8) | 64'(b[k + j]);
                else     w = w | (64'(b[k + j]) << (8 * j));
            end
            e.addr = a;
            e.data = w;
            exp_q[i].push_back(e);
            a++;
            k += bpw;
        end
        return (a > last) ? k : b.size();
    endfunction

    task automatic mon(input int i, input logic we, input logic [17:0] a, input logic [63:0] d,
                       input logic unl, input logic busy, input logic done);
        wr_t e;
        checks++;
        if (busy && done) fail("busy_and_done", {busy, done}, 2'b00);
        checks++;
        if (unl && done) fail("unload_in_done", unl, 0);
        if (we === 1'b0) begin
            checks++;
            if (prev_we[i] === 1'b0) fail("we_pulse_len", 2, 1);
            checks++;
            if (a !== prev_addr[i] || d !== prev_data[i]) fail("wr_setup", prev_data[i], d);
            if (exp_q[i].size() == 0) begin
                checks++;
                fail("unexpected_wr", {14'd0, a, d[31:0]}, 0);
            end else begin
                e = exp_q[i].pop_front();
                chk("wr_addr", 64'(a), 64'(e.addr));
                chk("wr_data", d, e.data);
            end
            wr_cnt[i]++;
            last_wa[i] = a;
            last_wd[i] = d;
        end
        prev_we[i]   = we;
        prev_addr[i] = a;
        prev_data[i] = d;
    endtask

    always @(negedge Clock) begin
        if (Resetn) begin
            mon(0, we_a, addr_a, 64'(data_a), unl_a, busy_a, done_a);
            mon(1, we_b, addr_b, 64'(data_b), unl_b, busy_b, done_b);
        end else begin
            prev_we[0] = 1'b1;
            prev_we[1] = 1'b1;
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_we_n"}, we_a, 1);
        chk({tag, "_unload"}, unl_a, 0);
        chk({tag, "_rx_en"}, en_a, 0);
        chk({tag, "_addr"}, addr_a, 0);
        chk({tag, "_data"}, data_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_cksum"}, cs_a, 0);
        chk({tag, "_b_data"}, data_b, 0);
    endtask

    task automatic init_pulse(input string tag);
        Initialize = 1'b1;
        @(negedge Clock);
        Initialize = 1'b0;
        check_idle(tag);
    endtask

    task automatic start_job(input int unsigned start, input int unsigned last, input bit hdr);
        Start_addr = 18'(start);
        Last_addr  = 18'(last);
        Header_en  = hdr;
        Enable     = 1'b1;
        @(negedge Clock);
        Enable = 1'b0;
        if (start > last) begin
            chk("empty_win_done", done_a, 1);
            chk("empty_win_rx_en", en_a, 0);
            chk("empty_win_busy", busy_a, 0);
        end else begin
            chk("start_busy", busy_a, 1);
            chk("start_rx_en", en_a, 1);
            chk("start_addr", addr_a, 64'(start));
        end
    endtask

    task automatic send_byte(input int i, input logic [7:0] b, input bit exp_taken, output bit taken);
        int n;
        taken = 1'b0;
        rx_data[i]  = b;
        rx_empty[i] = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge Clock);
            if (get_unl(i)) begin
                taken = 1'b1;
                break;
            end
        end
        rx_empty[i] = 1'b1;
        chk("byte_taken", taken, exp_taken);
        if (taken) begin
            n = 0;
            do begin
                @(negedge Clock);
                n++;
            end while (get_unl(i) && n < 20);
            chk("unload_release", n, 1);
        end
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while (!get_done(i) && n < 20) begin
            @(negedge Clock);
            n++;
        end
        #1;
        chk("done_reached", get_done(i), 1);
        chk("all_writes_seen", exp_q[i].size(), 0);
    endtask

    task automatic run(input int i, input logic [7:0] b[$], input int unsigned start,
                       input int unsigned last, input bit hdr);
        int consumed;
        bit tk;
        consumed = model(i, b, start, last, hdr);
        start_job(start, last, hdr);
        foreach (b[k]) begin
            send_byte(i, b[k], k < consumed, tk);
            if (!tk) break;
        end
        wait_done(i);
    endtask

    initial begin
        logic [7:0] q[$];
        bit tk;
        int base;
        rx_data[0] = 8'h00; rx_data[1] = 8'h00;
        rx_empty[0] = 1'b1; rx_empty[1] = 1'b1;
        wr_cnt[0] = 0; wr_cnt[1] = 0;
        repeat (3) @(negedge Clock);
        check_idle("reset");
        Resetn = 1'b1;
        @(negedge Clock);

        // 16-bit MSB-first, three words
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run(0, q, 0, 2, 1'b0);
        chk("s1_wr_cnt", wr_cnt[0], 3);
        chk("s1_last_data", last_wd[0], 64'h5566);
        chk("s1_addr", addr_a, 2);
        chk("s1_rx_en", en_a, 0);
        chk("s1_cksum", cs_a, CS_S1);
        init_pulse("s1_init");

        // header of three lines stripped before one word
        base = wr_cnt[0];
        q = '{8'h50, 8'h35, 8'h0A, 8'h34, 8'h20, 8'h32, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A,
              8'hAB, 8'hCD};
        run(0, q, 5, 5, 1'b1);
        chk("s2_wr_cnt", wr_cnt[0] - base, 1);
        chk("s2_last", {last_wa[0], last_wd[0][15:0]}, {18'd5, 16'hABCD});
        init_pulse("s2_init");

        // 32-bit LSB-first instance
        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run(1, q, 0, 0, 1'b0);
        chk("s3_wr_cnt", wr_cnt[1], 1);
        chk("s3_last_data", last_wd[1], 64'h04030201);
        init_pulse("s3_init");

        // top-of-memory window, second word refused
        base = wr_cnt[0];
        q = '{8'h12, 8'h34, 8'h56, 8'h78};
        run(0, q, 18'h3FFFF, 18'h3FFFF, 1'b0);
        chk("s4_wr_cnt", wr_cnt[0] - base, 1);
        chk("s4_addr_hold", addr_a, 18'h3FFFF);
        chk("s4_last_data", last_wd[0], 64'h1234);
        init_pulse("s4_init");

        // abort mid-word, then restart elsewhere
        base = wr_cnt[0];
        start_job(20, 30, 1'b0);
        send_byte(0, 8'h77, 1'b1, tk);
        init_pulse("s5_abort");
        chk("s5_no_write", wr_cnt[0] - base, 0);
        q = '{8'h9A, 8'hBC};
        run(0, q, 7, 7, 1'b0);
        chk("s5_last", {last_wa[0], last_wd[0][15:0]}, {18'd7, 16'h9ABC});
        init_pulse("s5_init");

        // inverted window
        base = wr_cnt[0];
        start_job(10, 4, 1'b0);
        send_byte(0, 8'h55, 1'b0, tk);
        chk("s6_no_write", wr_cnt[0] - base, 0);
        chk("s6_done_hold", done_a, 1);

        repeat (2) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/uart_sram_loader.md
Name: uart_sram_loader

Overview:
Parametrised byte-stream-to-SRAM loader: consumes bytes from a UART receive controller using the Empty/Unload handshake and assembles them into DATA_W-bit words.
Each completed word is written to SRAM over a programmable address window [Start_addr..Last_addr].
Optional header stripping (skip N line feeds) and selectable byte order.
Sits between the UART receive controller and the SRAM write port of the top level.

Parameters:
DATA_W, 16, SRAM word width; multiple of 8, range 8..64; BPW = DATA_W/8 bytes per word
ADDR_W, 18, SRAM address width
HEADER_LINES, 3, number of 8'h0A bytes discarded when Header_en=1; range 1..15
MSB_FIRST, 1, 1: first byte lands in [DATA_W-1:DATA_W-8]; 0: first byte lands in [7:0]

Ports:
Clock  in  1  system clock
Resetn  in  1  asynchronous active-low reset
Initialize  in  1  synchronous soft reset, highest priority after Resetn
Enable  in  1  start request, sampled in IDLE
Header_en  in  1  strip header before data; sampled with Enable
Start_addr  in  ADDR_W  first word address; sampled with Enable
Last_addr  in  ADDR_W  final word address, inclusive; sampled with Enable
RX_data  in  8  byte from receiver
RX_empty  in  1  receiver holds no byte
RX_unload  out  1  byte consumed
RX_enable  out  1  receiver enable
SRAM_address  out  ADDR_W  write address
SRAM_write_data  out  DATA_W  assembled word
SRAM_we_n  out  1  active-low write strobe
Busy  out  1  high outside IDLE/DONE
Done  out  1  high in DONE
Checksum  out  16  see Optional Feature

Behaviour:
- Reset (Resetn low, or Initialize high on a clock edge):
  - Outputs: SRAM_we_n=1, RX_unload=0, RX_enable=0, SRAM_address=0, SRAM_write_data=0, Busy=0, Done=0, Checksum=0.
  - Internal state: byte index=0, line-feed count=0, state=IDLE.
  - Initialize mid-operation aborts immediately; a partial word is never written.
- States: IDLE, HDR_WAIT, HDR_ACK, BYTE_WAIT, BYTE_ACK, WRITE, DONE.
- IDLE:
  - If Enable=1, latch Start_addr, Last_addr and Header_en; set SRAM_address=Start_addr and RX_enable=1.
  - Next state is HDR_WAIT if Header_en=1, else BYTE_WAIT.
  - If Start_addr > Last_addr, go directly to DONE instead; RX_enable stays 0 and no writes occur.
- Handshake, common to the *_WAIT/*_ACK pairs:
  - In a WAIT state with RX_empty=0: capture RX_data, RX_unload<=1, go to the matching ACK state.
  - In an ACK state, wait for RX_empty=1, then RX_unload<=0.
  - RX_unload is never high for fewer than 1 cycle and never held beyond the cycle after RX_empty=1 is seen.
- Header (HDR_WAIT/HDR_ACK):
  - A captured 8'h0A increments the count; all header bytes are discarded.
  - On ACK completion: count==HEADER_LINES goes to BYTE_WAIT, otherwise back to HDR_WAIT.
- Bytes (BYTE_WAIT/BYTE_ACK):
  - The byte goes into lane byte_idx, or lane BPW-1-byte_idx when MSB_FIRST=0; other lanes hold.
  - On ACK completion, if byte_idx==BPW-1: byte_idx<=0, go to WRITE. Otherwise byte_idx+1, go to BYTE_WAIT.
- WRITE:
  - SRAM_we_n=0 for exactly one cycle; address and data are stable during that cycle and the cycle before.
  - Next cycle, SRAM_we_n=1. If SRAM_address==Last_addr: RX_enable<=0, go to DONE, address holds. Otherwise address+1, go to BYTE_WAIT.
  - The address never wraps past Last_addr, including when Last_addr = 2^ADDR_W-1.
- DONE: Done=1; stays there until Initialize. Enable is ignored.
- Latency: from capture of the final byte of a word to the SRAM_we_n falling edge = (cycles for RX_empty to rise) + 1.
- Bytes arriving after DONE are not unloaded; overrun is the receiver's concern.

Optional Feature:
- Macro UART_SRAM_CHECKSUM_EN.
- Defined: Checksum is a 16-bit wrapping sum of every data byte captured in BYTE_WAIT (header bytes excluded). It clears on reset, on Initialize, and on Enable acceptance, and holds its value in DONE.
- Undefined: Checksum is tied to 16'd0 and no adder is synthesised.

Decomposition:
- Package uart_sram_pkg:
  - loader_state_t enum
  - LF_CHAR = 8'h0A
  - function lane_of(byte_idx, msb_first)
- Sub-module uart_byte_handshake (WAIT/ACK pair producing RX_unload and a one-cycle byte_valid strobe) is natural; instantiate it once and share it between header and data phases.

Test Plan:
1. DATA_W=16, MSB_FIRST=1, Start=0, Last=2, no header; send 11 22 33 44 55 66 -> writes 0:1122, 1:3344, 2:5566; Done=1; RX_enable=0; SRAM_address=2.
2. Header_en=1, HEADER_LINES=3; send "P5\n" "4 2\n" "255\n" AB CD with Start=Last=5 -> single write 5:ABCD; header bytes are never written.
3. DATA_W=32, MSB_FIRST=0; send 01 02 03 04 -> write data 04030201; SRAM_we_n low exactly 1 cycle.
4. Start=3FFFF, Last=3FFFF; send 2 words -> one write at 3FFFF, no wrap to 0; the second word is not unloaded.
5. Initialize asserted after 1 byte of a word -> no SRAM write, all outputs at reset values; a fresh Enable restarts at the new Start_addr.
6. Start=10, Last=4 -> DONE next cycle, zero writes, RX_enable stays 0. With UART_SRAM_CHECKSUM_EN, scenario 1 gives Checksum=16'h0165.
